// File: rtl/cp0_exc_handler_pkg.sv
// CP0 definitions shared by the exception handler and its timer:
// register numbers, excepttype codes, ExcCode values, bit positions and
// the exception decode helper.
package cp0_defs;

  // CP0 register numbers
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  // excepttype codes from the exception detector
  localparam logic [31:0] EXCTYPE_INT     = 32'h1;
  localparam logic [31:0] EXCTYPE_ADEL    = 32'h4;
  localparam logic [31:0] EXCTYPE_ADES    = 32'h5;
  localparam logic [31:0] EXCTYPE_SYSCALL = 32'h8;
  localparam logic [31:0] EXCTYPE_BREAK   = 32'h9;
  localparam logic [31:0] EXCTYPE_RI      = 32'ha;
  localparam logic [31:0] EXCTYPE_OV      = 32'hc;
  localparam logic [31:0] EXCTYPE_ERET    = 32'he;

  // Cause.ExcCode values
  typedef enum logic [4:0] {
    EXCCODE_INT  = 5'h00,
    EXCCODE_ADEL = 5'h04,
    EXCCODE_ADES = 5'h05,
    EXCCODE_SYS  = 5'h08,
    EXCCODE_BP   = 5'h09,
    EXCCODE_RI   = 5'h0a,
    EXCCODE_OV   = 5'h0c
  } exc_code_e;

  // Bit positions
  localparam int STATUS_EXL = 1;
  localparam int CAUSE_BD   = 31;
  localparam int CAUSE_IP7  = 15;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;
  localparam logic [31:0] STATUS_RST_DEF = 32'h0040_0000;

  typedef struct packed {
    logic      commit;    // known exception that updates CP0 state
    logic      badaddr;   // BadVAddr must capture the faulting address
    exc_code_e code;
  } exc_dec_t;

  // Classify an excepttype code (eret and unknown codes do not commit).
  function automatic exc_dec_t exc_decode(input logic [31:0] t);
    exc_dec_t d;
    d = '{commit: 1'b1, badaddr: 1'b0, code: EXCCODE_INT};
    case (t)
      EXCTYPE_INT:     d.code = EXCCODE_INT;
      EXCTYPE_ADEL:    begin d.code = EXCCODE_ADEL; d.badaddr = 1'b1; end
      EXCTYPE_ADES:    begin d.code = EXCCODE_ADES; d.badaddr = 1'b1; end
      EXCTYPE_SYSCALL: d.code = EXCCODE_SYS;
      EXCTYPE_BREAK:   d.code = EXCCODE_BP;
      EXCTYPE_RI:      d.code = EXCCODE_RI;
      EXCTYPE_OV:      d.code = EXCCODE_OV;
      default:         d.commit = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cp0_exc_handler_timer.sv
// cp0_timer: Count/Compare pair with a divide-by-two Count tick and a
// sticky timer interrupt. Only instantiated when CP0_TIMER_INT_EN is defined.
module cp0_timer
  import cp0_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic [31:0] count_q, compare_q;
  logic        tog_q, timer_int_q;

  // Count ticks on every other clock, mtc0 writes take precedence; the
  // interrupt is sticky until software rewrites Compare.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      compare_q   <= '0;
      tog_q       <= 1'b0;
      timer_int_q <= 1'b0;
    end else begin
      tog_q <= ~tog_q;
      if (count_we_i)  count_q <= wdata_i;
      else if (tog_q)  count_q <= count_q + 32'd1;
      if (compare_we_i) compare_q <= wdata_i;
      if (compare_we_i)
        timer_int_q <= 1'b0;
      else if ((count_q == compare_q) && (compare_q != '0))
        timer_int_q <= 1'b1;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = timer_int_q;

endmodule

// File: rtl/cp0_exc_handler.sv
// cp0_exc_handler: CP0 register file plus exception commit. Commits the
// registered excepttype code and pulses flush_o with the redirect PC one
// cycle later. Optional Count/Compare timer: define CP0_TIMER_INT_EN.
module cp0_exc_handler
  import cp0_defs::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [31:0] STATUS_RST = STATUS_RST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cur_pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  input  logic [5:0]  int_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        flush_o,
  output logic [31:0] newpc_o,
  output logic        timer_int_o
);

  logic [31:0] status_q, status_d, cause_q, cause_d, epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d, newpc_q, newpc_d;
  logic        flush_q, flush_d;
  logic [31:0] count, compare, epc_seen;
  logic        timer_int;
  exc_dec_t    dec;

`ifdef CP0_TIMER_INT_EN
  cp0_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we_i   (we_i && (waddr_i == REG_COUNT)),
    .compare_we_i (we_i && (waddr_i == REG_COMPARE)),
    .wdata_i      (wdata_i),
    .count_o      (count),
    .compare_o    (compare),
    .timer_int_o  (timer_int)
  );
`else
  assign count     = '0;
  assign compare   = '0;
  assign timer_int = 1'b0;
`endif

  // Next-state: mtc0 first, then the exception commit overrides its fields.
  // NOTE: every always_comb output gets a default up front so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    dec        = exc_decode(excepttype_i);
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;

    if (we_i) begin
      case (waddr_i)
        REG_STATUS: status_d     = wdata_i;
        REG_CAUSE:  cause_d[9:8] = wdata_i[9:8];
        REG_EPC:    epc_d        = wdata_i;
        default:    ;
      endcase
    end
    // eret returns to EPC including a same-cycle mtc0 EPC write
    epc_seen = epc_d;

    cause_d[15:10] = {int_i[5] | timer_int, int_i[4:0]};

    if (dec.commit) begin
      if (!status_q[STATUS_EXL]) begin
        epc_d             = in_delayslot_i ? cur_pc_i - 32'd4 : cur_pc_i;
        cause_d[CAUSE_BD] = in_delayslot_i;
      end
      status_d[STATUS_EXL] = 1'b1;
      cause_d[6:2]         = dec.code;
      if (dec.badaddr) badvaddr_d = bad_addr_i;
    end else if (excepttype_i == EXCTYPE_ERET) begin
      status_d[STATUS_EXL] = 1'b0;
    end

    flush_d = (excepttype_i != '0);
    if (excepttype_i == EXCTYPE_ERET) newpc_d = epc_seen;
    else if (flush_d)                 newpc_d = EXC_VECTOR;
    else                              newpc_d = newpc_q;
  end

  // CP0 state and the registered flush/redirect outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q   <= STATUS_RST;
      cause_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      flush_q    <= 1'b0;
      newpc_q    <= '0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      flush_q    <= flush_d;
      newpc_q    <= newpc_d;
    end
  end

  // mfc0 read port with same-cycle mtc0 bypass
  always_comb begin
    rdata_o = '0;
    if (we_i && (waddr_i == raddr_i)) begin
      rdata_o = wdata_i;
    end else begin
      case (raddr_i)
        REG_BADVADDR: rdata_o = badvaddr_q;
        REG_COUNT:    rdata_o = count;
        REG_COMPARE:  rdata_o = compare;
        REG_STATUS:   rdata_o = status_q;
        REG_CAUSE:    rdata_o = cause_q;
        REG_EPC:      rdata_o = epc_q;
        default:      rdata_o = '0;
      endcase
    end
  end

  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign flush_o     = flush_q;
  assign newpc_o     = newpc_q;
  assign timer_int_o = timer_int;

endmodule

// File: tb/tb_cp0_exc_handler.sv
// Testbench for cp0_exc_handler: directed vectors, flush redirects checked
// through a scoreboard queue by an independent monitor; CP0 registers are
// checked through the mfc0 port.
module tb_cp0_exc_handler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] excepttype_i = '0;
  logic [31:0] cur_pc_i = '0;
  logic        in_delayslot_i = 1'b0;
  logic [31:0] bad_addr_i = '0;
  logic [5:0]  int_i = '0;
  logic        we_i = 1'b0;
  logic [4:0]  waddr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [4:0]  raddr_i = '0;
  logic [31:0] rdata_o, status_o, cause_o, epc_o, newpc_o;
  logic        flush_o, timer_int_o;

  cp0_exc_handler dut (
    .clk(clk), .rst(rst),
    .excepttype_i(excepttype_i), .cur_pc_i(cur_pc_i),
    .in_delayslot_i(in_delayslot_i), .bad_addr_i(bad_addr_i),
    .int_i(int_i), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .raddr_i(raddr_i), .rdata_o(rdata_o),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .flush_o(flush_o), .newpc_o(newpc_o), .timer_int_o(timer_int_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Monitor: every flush pulse must match the oldest expected redirect
  always @(negedge clk) begin
    if (!rst && flush_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_flush: got newpc %h, want no flush", newpc_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.tag, newpc_o, e.pc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exc_set(input logic [31:0] code, input logic [31:0] pc,
                         input logic ds, input logic [31:0] bad,
                         input string tag, input logic [31:0] exp_pc);
    excepttype_i   = code;
    cur_pc_i       = pc;
    in_delayslot_i = ds;
    bad_addr_i     = bad;
    exp_q.push_back('{tag: tag, pc: exp_pc});
  endtask

  task automatic exc_one(input logic [31:0] code, input logic [31:0] pc,
                         input logic ds, input logic [31:0] bad,
                         input string tag, input logic [31:0] exp_pc);
    exc_set(code, pc, ds, bad, tag, exp_pc);
    tick();
    excepttype_i = '0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wdata_i = d;
    tick();
    we_i = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp,
                    input string name);
    raddr_i = a;
    #1;
    check(name, rdata_o, exp);
  endtask

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // 1. reset state
    rd(5'd12, 32'h0040_0000, "rst_status");
    rd(5'd13, 32'h0, "rst_cause");
    rd(5'd14, 32'h0, "rst_epc");
    rd(5'd8,  32'h0, "rst_badvaddr");
    check("rst_flush", 32'(flush_o), 32'd0);
    check("rst_timer_int", 32'(timer_int_o), 32'd0);

    // hardware interrupt lines land in Cause.IP[7:2]
    int_i = 6'h2A;
    tick();
    rd(5'd13, 32'h0000_A800, "cause_ip");
    int_i = 6'h00;
    tick();

    // 2. syscall, not in delay slot
    exc_one(32'h8, 32'hBFC0_0100, 1'b0, 32'h0, "syscall_vec", VEC);
    rd(5'd14, 32'hBFC0_0100, "syscall_epc");
    rd(5'd13, 32'h0000_0020, "syscall_cause");
    rd(5'd12, 32'h0040_0002, "syscall_status");
    exc_one(32'he, 32'h0, 1'b0, 32'h0, "eret1_pc", 32'hBFC0_0100);
    rd(5'd12, 32'h0040_0000, "eret1_status");

    // 3. AdEL in a delay slot
    exc_one(32'h4, 32'h0000_0200, 1'b1, 32'h0000_1003, "adel_vec", VEC);
    rd(5'd14, 32'h0000_01FC, "adel_epc");
    rd(5'd13, 32'h8000_0010, "adel_cause");
    rd(5'd8,  32'h0000_1003, "adel_badvaddr");

    // 4. nested exception with EXL=1, then eret
    exc_one(32'hc, 32'h0000_0500, 1'b0, 32'h0, "ov_vec", VEC);
    rd(5'd14, 32'h0000_01FC, "ov_epc_hold");
    rd(5'd13, 32'h8000_0030, "ov_cause");
    rd(5'd8,  32'h0000_1003, "ov_badvaddr_hold");
    exc_one(32'he, 32'h0, 1'b0, 32'h0, "eret2_pc", 32'h0000_01FC);
    rd(5'd12, 32'h0040_0000, "eret2_status");

    // 5. same-cycle mtc0 EPC and eret
    we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'h0000_0400;
    exc_one(32'he, 32'h0, 1'b0, 32'h0, "eret_bypass_pc", 32'h0000_0400);
    we_i = 1'b0;
    rd(5'd14, 32'h0000_0400, "mtc0_epc");
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, 32'h8000_0330, "cause_mask");

    // read bypass and read-only BadVAddr
    we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'h0000_1234;
    rd(5'd14, 32'h0000_1234, "read_bypass");
    we_i = 1'b0;
    tick();
    mtc0(5'd8, 32'hDEAD_BEEF);
    rd(5'd8, 32'h0000_1003, "badvaddr_ro");
    rd(5'd20, 32'h0, "unmapped_reg");

    // back-to-back codes: two pulses; the second sees EXL=1
    exc_set(32'h8, 32'h0000_0600, 1'b0, 32'h0, "b2b_first", VEC);
    tick();
    exc_set(32'h9, 32'h0000_0700, 1'b1, 32'h0, "b2b_second", VEC);
    tick();
    excepttype_i = '0;
    rd(5'd14, 32'h0000_0600, "b2b_epc");
    rd(5'd13, 32'h0000_0324, "b2b_cause");

    // unknown nonzero code: redirect only
    exc_one(32'h3, 32'h0000_0800, 1'b1, 32'h0000_5555, "unknown_vec", VEC);
    rd(5'd13, 32'h0000_0324, "unknown_cause");
    rd(5'd12, 32'h0040_0002, "unknown_status");
    rd(5'd14, 32'h0000_0600, "unknown_epc");

    // same-cycle mtc0 Status and interrupt commit: commit owns EXL
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h0000_FF01;
    exc_one(32'h1, 32'h0000_0900, 1'b0, 32'h0, "int_vec", VEC);
    we_i = 1'b0;
    rd(5'd12, 32'h0000_FF03, "int_status");
    rd(5'd13, 32'h0000_0300, "int_cause");

    // reset during a flush pulse clears it asynchronously
    excepttype_i = 32'h8;
    tick();
    excepttype_i = '0;
    check("flush_before_reset", 32'(flush_o), 32'd1);
    rst = 1'b1;
    #1;
    check("flush_async_reset", 32'(flush_o), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    rd(5'd12, 32'h0040_0000, "post_rst_status");

`ifdef CP0_TIMER_INT_EN
    // 6. timer interrupt
    begin
      int lat;
      mtc0(5'd11, 32'd10);
      mtc0(5'd9, 32'd0);
      lat = 0;
      while (!timer_int_o && lat < 40) begin
        tick();
        lat++;
      end
      check("timer_int_set", 32'(timer_int_o), 32'd1);
      check("timer_latency", 32'((lat >= 19) && (lat <= 22)), 32'd1);
      tick();
      rd(5'd13, 32'h0000_8000, "timer_cause_ip7");
      mtc0(5'd11, 32'd0);
      check("timer_int_clear", 32'(timer_int_o), 32'd0);
      tick();
      tick();
      check("timer_int_stays_clear", 32'(timer_int_o), 32'd0);
    end
`else
    // timer compiled out: Count/Compare absent
    mtc0(5'd9, 32'd5);
    mtc0(5'd11, 32'd7);
    rd(5'd9,  32'h0, "no_timer_count");
    rd(5'd11, 32'h0, "no_timer_compare");
    check("no_timer_int", 32'(timer_int_o), 32'd0);
`endif

    tick();
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
